// File: rtl/serial_nibble_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_nibble_collector_if
// Description : Bundles the serial input stream, the control strobes and the
//               valid/ready word output of serial_nibble_collector.
//                 si, si_valid   - qualified serial bit stream (into collector)
//                 flush, clr_ovf - partial-word discard / overflow clear
//                 out_data/out_valid/out_ready - word handshake (from collector)
//                 busy, overflow, parity_err   - status (from collector)
//               modport slave  : the collector
//               modport master : the producer/consumer driving the collector
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_nibble_collector_if #(
  parameter int WIDTH = 4
);
  logic             si;
  logic             si_valid;
  logic             flush;
  logic             clr_ovf;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overflow;
  logic             parity_err;

  modport slave (
    input  si, si_valid, flush, clr_ovf, out_ready,
    output out_data, out_valid, busy, overflow, parity_err
  );

  modport master (
    output si, si_valid, flush, clr_ovf, out_ready,
    input  out_data, out_valid, busy, overflow, parity_err
  );
endinterface
`default_nettype wire

// File: rtl/serial_nibble_collector.sv
`default_nettype none
// ============================================================================
// Module      : serial_nibble_collector
// Description : Assembles a qualified serial bit stream LSB-first into
//               WIDTH-bit words and presents each completed word through a
//               one-word valid/ready holding buffer. Words completing while
//               the buffer is full and not being drained are dropped and
//               flagged in a sticky overflow bit.
//               Optional build macro PARITY_CHECK_EN: each word is followed by
//               one even-parity bit; parity_err is registered with out_data.
//               Without the macro parity_err is tied to 0.
// Ports       : clk   - rising-edge clock
//               reset - synchronous active-high reset
//               bus   - serial_nibble_collector_if.slave (stream in, word out)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_nibble_collector #(
  parameter int WIDTH = 4
) (
  input  wire                          clk,
  input  wire                          reset,
  serial_nibble_collector_if.slave     bus
);

  localparam int                 c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
  } state_t;
`endif

  state_t             r_state;
  logic [WIDTH-1:0]   r_sr;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_ovf;

  // flush outranks a coincident bit, so that bit is never accepted
  logic             w_accept;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_last_data;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;
  logic             w_drop;

  assign w_accept    = bus.si_valid && !bus.flush;
  assign w_sr_next   = {bus.si, r_sr[WIDTH-1:1]};
  assign w_last_data = w_accept && (r_state != state_t'(2'd2)) && (r_cnt == c_last);

`ifdef PARITY_CHECK_EN
  logic r_par;
  logic w_par;
  // Word is already complete in r_sr while waiting for the parity bit
  assign w_complete = w_accept && (r_state == S_PARITY);
  assign w_word     = r_sr;
  assign w_par      = ^{r_sr, bus.si};
`else
  // Completion is combinational with the last data bit
  assign w_complete = w_last_data;
  assign w_word     = w_sr_next;
`endif

  assign w_drop = w_complete && r_out_valid && !bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_par       <= 1'b0;
`endif
    end else begin
      // Assembly side
      if (bus.flush) begin
        r_state <= S_IDLE;
        r_sr    <= '0;
        r_cnt   <= '0;
      end else if (bus.si_valid) begin
        case (r_state)
          S_IDLE, S_SHIFT: begin
            r_sr <= w_sr_next;
            if (w_last_data) begin
              r_cnt <= '0;
`ifdef PARITY_CHECK_EN
              r_state <= S_PARITY;
`else
              r_state <= S_IDLE;
`endif
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_SHIFT;
            end
          end
`ifdef PARITY_CHECK_EN
          S_PARITY: r_state <= S_IDLE;
`endif
          default: r_state <= S_IDLE;
        endcase
      end

      // Holding buffer: load when empty or drained on this same edge
      if (w_complete && (!r_out_valid || bus.out_ready)) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
        r_par       <= w_par;
`endif
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Sticky overflow; a drop on the same edge beats the clear
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.overflow  = r_ovf;
`ifdef PARITY_CHECK_EN
  assign bus.busy       = (r_cnt != '0) || (r_state == S_PARITY);
  assign bus.parity_err = r_par;
`else
  assign bus.busy       = (r_cnt != '0);
  assign bus.parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
